// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty ramp and the PWM generator.
package pwm_pkg;

    localparam int DUTY_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_e;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV enabled clocks.
module pwm_tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = $clog2(TICK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Soft-start controller: walks PWM_ontime toward an accepted target
// in saturating steps of STEP, one step per TICK_DIV clocks.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int unsigned       TICK_DIV  = 4,
    parameter int unsigned       STEP      = 16,
    parameter logic [DUTY_W-1:0] INIT_DUTY = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DUTY_W-1:0] target_duty,
    input  logic              target_valid,
    output logic              target_ready,
    input  logic              hold,
    output logic [DUTY_W-1:0] PWM_ontime,
    output logic              ramp_busy,
    output logic              ramp_done
);

    localparam logic [DUTY_W:0] STEP9 = (DUTY_W + 1)'(STEP);

    ramp_state_e       state_q;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] target_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;

    logic              accept;
    logic              tick;
    logic              tick_en;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W:0]   dn_lim;
    logic [DUTY_W-1:0] step_d;

    assign accept  = target_valid && ready_q;
    assign tick_en = busy_q && !hold;

    pwm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (accept),
        .en_i   (tick_en),
        .tick_o (tick)
    );

    // 9-bit arithmetic so neither direction can wrap past the rails.
    always_comb begin
        up_sum = {1'b0, duty_q} + STEP9;
        dn_lim = {1'b0, target_q} + STEP9;
        step_d = target_q;
        if (state_q == RAMP_UP) begin
            if (up_sum < {1'b0, target_q}) begin
                step_d = up_sum[DUTY_W-1:0];
            end
        end else if (state_q == RAMP_DOWN) begin
            if ({1'b0, duty_q} > dn_lim) begin
                step_d = duty_q - STEP9[DUTY_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            duty_q   <= INIT_DUTY;
            target_q <= INIT_DUTY;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        target_q <= target_duty;
                        if (target_duty > duty_q) begin
                            state_q <= RAMP_UP;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else if (target_duty < duty_q) begin
                            state_q <= RAMP_DOWN;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (tick) begin
                        duty_q <= step_d;
                        if (step_d == target_q) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign PWM_ontime   = duty_q;
    assign target_ready = ready_q;
    assign ramp_busy    = busy_q;
    assign ramp_done    = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: per-cycle model compare plus directed
// literal checkpoints for ramp, clamp, saturation, hold and reset.
module tb_pwm_duty_ramp;

    localparam int TD   = 4;
    localparam int STP  = 16;
    localparam int INIT = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] target_duty = '0;
    logic       target_valid = 1'b0;
    logic       target_ready;
    logic       hold = 1'b0;
    logic [7:0] PWM_ontime;
    logic       ramp_busy;
    logic       ramp_done;

    int n_pass = 0;
    int n_total = 0;

    pwm_duty_ramp #(
        .TICK_DIV  (TD),
        .STEP      (STP),
        .INIT_DUTY (8'(INIT))
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .target_duty  (target_duty),
        .target_valid (target_valid),
        .target_ready (target_ready),
        .hold         (hold),
        .PWM_ontime   (PWM_ontime),
        .ramp_busy    (ramp_busy),
        .ramp_done    (ramp_done)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: duty after n ticks is start +/- n*STEP clipped at target.
    int m_duty = INIT;
    int m_start = INIT;
    int m_target = INIT;
    int m_k = 0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_up = 1'b0;

    always @(posedge clk or posedge reset) begin
        int n;
        if (reset) begin
            m_duty = INIT;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_k    = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (target_valid) begin
                    if (int'(target_duty) == m_duty) begin
                        m_done = 1'b1;
                    end else begin
                        m_busy   = 1'b1;
                        m_up     = int'(target_duty) > m_duty;
                        m_start  = m_duty;
                        m_target = int'(target_duty);
                        m_k      = 0;
                    end
                end
            end else if (!hold) begin
                m_k++;
                if (m_k % TD == 0) begin
                    n = m_k / TD;
                    if (m_up) begin
                        m_duty = m_start + n * STP;
                        if (m_duty > m_target) m_duty = m_target;
                    end else begin
                        m_duty = m_start - n * STP;
                        if (m_duty < m_target) m_duty = m_target;
                    end
                    if (m_duty == m_target) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_duty", int'(PWM_ontime), m_duty);
        chk("m_ready", int'(target_ready), int'(!m_busy));
        chk("m_busy", int'(ramp_busy), int'(m_busy));
        chk("m_done", int'(ramp_done), int'(m_done));
    end

    task automatic wait_clks(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic accept(logic [7:0] d);
        target_duty  = d;
        target_valid = 1'b1;
        @(negedge clk);
        target_valid = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_duty", int'(PWM_ontime), 0);
        chk("rst_ready", int'(target_ready), 1);
        chk("rst_busy", int'(ramp_busy), 0);
        chk("rst_done", int'(ramp_done), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        accept(8'h40);
        chk("up_k0_ready", int'(target_ready), 0);
        chk("up_k0_busy", int'(ramp_busy), 1);
        wait_clks(3);
        chk("up_k3", int'(PWM_ontime), 8'h00);
        wait_clks(1);
        chk("up_k4", int'(PWM_ontime), 8'h10);
        wait_clks(4);
        chk("up_k8", int'(PWM_ontime), 8'h20);
        wait_clks(4);
        chk("up_k12", int'(PWM_ontime), 8'h30);
        chk("up_k12_done", int'(ramp_done), 0);
        wait_clks(4);
        chk("up_k16", int'(PWM_ontime), 8'h40);
        chk("up_k16_done", int'(ramp_done), 1);
        chk("up_k16_ready", int'(target_ready), 1);
        wait_clks(1);
        chk("up_k17_done", int'(ramp_done), 0);

        accept(8'h35);
        wait_clks(4);
        chk("clamp_dn", int'(PWM_ontime), 8'h35);
        chk("clamp_done", int'(ramp_done), 1);
        wait_clks(1);

        accept(8'hF5);
        wait_clks(48);
        chk("to_f5", int'(PWM_ontime), 8'hF5);
        wait_clks(1);
        accept(8'hFF);
        wait_clks(4);
        chk("sat_ff", int'(PWM_ontime), 8'hFF);
        chk("sat_ff_done", int'(ramp_done), 1);
        wait_clks(1);

        accept(8'h08);
        wait_clks(64);
        chk("to_08", int'(PWM_ontime), 8'h08);
        wait_clks(1);
        accept(8'h00);
        wait_clks(4);
        chk("sat_00", int'(PWM_ontime), 8'h00);
        chk("sat_00_done", int'(ramp_done), 1);
        wait_clks(1);

        accept(8'h40);
        wait_clks(6);
        hold         = 1'b1;
        target_duty  = 8'h99;
        target_valid = 1'b1;
        wait_clks(10);
        chk("hold_duty", int'(PWM_ontime), 8'h10);
        chk("hold_ready", int'(target_ready), 0);
        hold         = 1'b0;
        target_valid = 1'b0;
        wait_clks(1);
        chk("resume_k7", int'(PWM_ontime), 8'h10);
        wait_clks(1);
        chk("resume_k8", int'(PWM_ontime), 8'h20);
        wait_clks(4);
        chk("pre_rst", int'(PWM_ontime), 8'h30);

        #2 reset = 1'b1;
        #1;
        chk("mid_rst_duty", int'(PWM_ontime), 8'h00);
        chk("mid_rst_ready", int'(target_ready), 1);
        chk("mid_rst_busy", int'(ramp_busy), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        accept(8'h00);
        chk("eq_done", int'(ramp_done), 1);
        chk("eq_duty", int'(PWM_ontime), 8'h00);
        chk("eq_ready", int'(target_ready), 1);
        wait_clks(1);
        chk("eq_done_off", int'(ramp_done), 0);
        wait_clks(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
